mult_op_scheduler: RTL and testbench
====================================

Name: mult_op_scheduler

Overview:
Upstream issue stage for the shift-and-add sequential multiplier.
- Accepts tagged operand pairs on a valid/ready interface and buffers them in a DEPTH-entry FIFO.
- Drives the multiplier's start/a/b interface one operation at a time and collects product on done.
- Presents each result with its tag on a valid/ready output, giving back-pressure-aware, in-order multiply service to client logic.

Parameters:
WIDTH, 8, operand width; product is 2*WIDTH.
DEPTH, 4, operand FIFO entries; power of two, >= 2.
TAG_W, 4, width of caller tag carried with each operation.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand pair offered.
in_ready  output  1  FIFO can accept; equals (fifo_count < DEPTH) from registered count.
in_a  input  WIDTH  multiplicand.
in_b  input  WIDTH  multiplier.
in_tag  input  TAG_W  caller tag.
mul_start  output  1  start pulse to multiplier.
mul_a  output  WIDTH  multiplicand to multiplier.
mul_b  output  WIDTH  multiplier operand to multiplier.
mul_busy  input  1  multiplier busy.
mul_done  input  1  multiplier done (level; stays high until the next start is accepted).
mul_product  input  2*WIDTH  multiplier product.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_product  output  2*WIDTH  captured product.
res_tag  output  TAG_W  tag of the captured result.
fifo_count  output  $clog2(DEPTH)+1  entries currently buffered.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, FIFO empty, fifo_count=0, in_ready=1, mul_start=0, mul_a=0, mul_b=0, res_valid=0, res_product=0, res_tag=0. Reset mid-operation discards FIFO contents and any in-flight op; the multiplier is reset by the same rst_n.
- Push: occurs when in_valid && in_ready; a full FIFO never accepts, even in a pop cycle.
- Push/pop same cycle: simultaneous push and pop leaves fifo_count unchanged.
- Pointers: FIFO pointers wrap modulo DEPTH.
- Head visibility: a pushed entry is visible at the head the cycle after the push.
- IDLE: when the FIFO is non-empty, mul_busy=0 and res_valid=0, do all of the following, then go to ISSUE:
  - pop head;
  - load mul_a/mul_b from the head;
  - load tag_r from the head tag.
- ISSUE: mul_start=1 for exactly this one cycle; mul_a/mul_b stable. Go to ACK unconditionally.
- ACK: wait for mul_busy=1, then go to RUN. mul_done is ignored here because it may be stale-high from the previous operation.
- RUN: on mul_done=1 && mul_busy=0:
  - res_product <= mul_product;
  - res_tag <= tag_r;
  - res_valid <= 1;
  - go to HOLD.
- HOLD: res_valid, res_product and res_tag are held stable until res_ready. On res_valid && res_ready: res_valid <= 0 and go to IDLE.
- Next issue: the earliest next issue is the cycle after returning to IDLE.
- mul_start: low in every state except ISSUE.
- Register stability: mul_a and mul_b hold their last values outside ISSUE.
- Scheduler latencies:
  - push into empty FIFO at cycle t -> IDLE pop decision at t+1 -> mul_start high at t+2;
  - mul_done seen in RUN at cycle d -> res_valid high at d+1.
- Ordering: results leave strictly in push order; only one op is in flight at a time.
- Overflow: none; products are full 2*WIDTH.
- Illegal state encoding: recovers to IDLE.

Decomposition:
- Package mult_sched_pkg: state enum sched_state_t {IDLE, ISSUE, ACK, RUN, HOLD}, plus a localparam helper for the count width.
- Sub-module mult_op_fifo: parameterised synchronous FIFO (WIDTH*2+TAG_W data, DEPTH) with push, pop, head, count, full and empty.
- The top level holds the FSM and the result registers.

Test Plan:
- Reset, then push (a=3, b=5, tag=1) -> mul_start high exactly one cycle 2 cycles after the push, with mul_a=3 and mul_b=5; after done, res_valid=1, res_product=15, res_tag=1.
- Push 4 ops back-to-back (255x255, 0x7, 1x1, 16x16) -> fifo_count reaches 4 and in_ready=0 while full; results in order 65025, 0, 1, 256 with tags 0..3.
- Hold res_ready=0 for 20 cycles after the first result -> res_valid/res_product/res_tag stable, mul_start stays low, no second issue; release -> next issue follows.
- Stale done: the previous op leaves mul_done=1, then a new op is issued -> no result is captured until mul_busy is seen high then mul_done rises; res_product equals the new product.
- Assert rst_n=0 in RUN with 2 entries queued -> all outputs return to reset values immediately, fifo_count=0, and no result is emitted after release.
- Full FIFO with a simultaneous in_valid and pop -> no push accepted that cycle; fifo_count decrements by 1.

Source files
------------

// File: rtl/mult_op_scheduler_pkg.sv
// Shared types for the multiply-operation scheduler: FSM state encoding and
// the width helper for the FIFO occupancy counter.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    RUN,
    HOLD
  } sched_state_t;

  // The counter must represent DEPTH itself, hence one bit beyond the pointer width.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mult_op_scheduler_if.sv
// Bundle of client-side, multiplier-side and result-side signals of the scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic's view.
interface mult_op_scheduler_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  import mult_sched_pkg::*;

  localparam int CNT_W = count_width(DEPTH);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_W-1:0]     in_tag;
  logic                 mul_start;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mul_busy;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_product;
  logic [TAG_W-1:0]     res_tag;
  logic [CNT_W-1:0]     fifo_count;

  modport master (
    input  in_valid, in_a, in_b, in_tag, mul_busy, mul_done, mul_product, res_ready,
    output in_ready, mul_start, mul_a, mul_b, res_valid, res_product, res_tag, fifo_count
  );

  modport slave (
    output in_valid, in_a, in_b, in_tag, mul_busy, mul_done, mul_product, res_ready,
    input  in_ready, mul_start, mul_a, mul_b, res_valid, res_product, res_tag, fifo_count
  );

endinterface

// File: rtl/mult_op_scheduler_fifo.sv
// Small synchronous FIFO holding tagged operand pairs; pointers wrap modulo DEPTH
// and a full FIFO refuses a push even when a pop happens in the same cycle.
module mult_op_fifo
  import mult_sched_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             push_data,
  output logic [DATA_W-1:0]             head,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mult_op_scheduler.sv
// Issue stage for the sequential multiplier: buffers tagged operand pairs, runs
// them one at a time through the multiplier and returns tagged products in order.
module mult_op_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  mult_op_scheduler_if.master bus
);

  localparam int DATA_W = 2*WIDTH + TAG_W;
  localparam int CNT_W  = count_width(DEPTH);

  sched_state_t         state_q;
  sched_state_t         state_d;
  logic                 pop;
  logic                 capture;
  logic                 release_res;
  logic [DATA_W-1:0]    head;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic [WIDTH-1:0]     mul_a_q;
  logic [WIDTH-1:0]     mul_b_q;
  logic [TAG_W-1:0]     tag_r;
  logic                 res_valid_q;
  logic [2*WIDTH-1:0]   res_product_q;
  logic [TAG_W-1:0]     res_tag_q;

  mult_op_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.in_valid),
    .pop       (pop),
    .push_data ({bus.in_a, bus.in_b, bus.in_tag}),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign bus.in_ready    = !full;
  assign bus.fifo_count  = count;
  assign bus.mul_start   = (state_q == ISSUE);
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_product = res_product_q;
  assign bus.res_tag     = res_tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ACK only waits for busy: done may still be high from the previous product.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.mul_busy && !res_valid_q) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = ACK;
      ACK: begin
        if (bus.mul_busy) state_d = RUN;
      end
      RUN: begin
        if (bus.mul_done && !bus.mul_busy) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          release_res = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      tag_r         <= '0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      res_tag_q     <= '0;
    end else begin
      if (pop) {mul_a_q, mul_b_q, tag_r} <= head;
      if (capture) begin
        res_product_q <= bus.mul_product;
        res_tag_q     <= tag_r;
        res_valid_q   <= 1'b1;
      end else if (release_res) begin
        res_valid_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_op_scheduler.sv
// Self-checking bench for mult_op_scheduler: a behavioural multiplier with
// randomised latency plus an in-order scoreboard of products computed from stimulus.
module tb_mult_op_scheduler;
  import mult_sched_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int PW    = 2*WIDTH;

  typedef struct packed {
    logic [PW-1:0]    p;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  mult_op_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus();

  mult_op_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Multiplier stand-in: busy rises busy_delay_cfg cycles after start, done stays
  // high (with the old product) until busy rises for the next operation.
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  int               dly_cnt;
  int               lat_cnt;
  bit               pending;
  int               busy_delay_cfg = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_busy    <= 1'b0;
      bus.mul_done    <= 1'b0;
      bus.mul_product <= '0;
      pending         <= 1'b0;
      dly_cnt         <= 0;
      lat_cnt         <= 0;
    end else if (bus.mul_start) begin
      pending <= 1'b1;
      dly_cnt <= busy_delay_cfg;
      m_a     <= bus.mul_a;
      m_b     <= bus.mul_b;
    end else if (pending) begin
      if (dly_cnt == 0) begin
        pending      <= 1'b0;
        bus.mul_busy <= 1'b1;
        bus.mul_done <= 1'b0;
        lat_cnt      <= $urandom_range(1, 6);
      end else begin
        dly_cnt <= dly_cnt - 1;
      end
    end else if (bus.mul_busy) begin
      if (lat_cnt <= 1) begin
        bus.mul_busy    <= 1'b0;
        bus.mul_done    <= 1'b1;
        bus.mul_product <= PW'(m_a) * PW'(m_b);
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  function automatic logic [PW-1:0] ref_mul(input int a, input int b);
    return PW'(a * b);
  endfunction

  // Offer one operand pair at a negedge and hold it until accepted.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [TAG_W-1:0] t, output bit ok);
    exp_t e;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = t;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (ok) begin
      e.p = ref_mul(int'(a), int'(b));
      e.t = t;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.res_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic grab_result(output logic [PW-1:0] p, output logic [TAG_W-1:0] t, output bit ok);
    ok = 1'b0;
    p  = '0;
    t  = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (bus.res_valid === 1'b1) begin
        p  = bus.res_product;
        t  = bus.res_tag;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start: got %0b expected 0", bus.mul_start); end
    checks++; if (bus.mul_a !== '0 || bus.mul_b !== '0) begin errors++; $display("[TB] FAIL reset_operands: got %0d/%0d expected 0/0", bus.mul_a, bus.mul_b); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %0b expected 0", bus.res_valid); end
    checks++; if (bus.res_product !== '0 || bus.res_tag !== '0) begin errors++; $display("[TB] FAIL reset_result: got %0d/%0d expected 0/0", bus.res_product, bus.res_tag); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    logic [PW-1:0] p;
    logic [TAG_W-1:0] t;
    applyStimulus(8'd3, 8'd5, 4'd1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_push: got timeout expected accept"); end
    checks++; if (bus.mul_start !== 1'b0 || bus.fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL single_t1: got start=%0b count=%0d expected start=0 count=1", bus.mul_start, bus.fifo_count); end
    @(negedge clk);
    checks++; if (bus.mul_start !== 1'b1) begin errors++; $display("[TB] FAIL single_start: got %0b expected 1", bus.mul_start); end
    checks++; if (bus.mul_a !== 8'd3 || bus.mul_b !== 8'd5) begin errors++; $display("[TB] FAIL single_operands: got %0d/%0d expected 3/5", bus.mul_a, bus.mul_b); end
    @(negedge clk);
    checks++; if (bus.mul_start !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse: got %0b expected 0", bus.mul_start); end
    grab_result(p, t, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_res_timeout: got none expected result"); end
    checks++; if (p !== 16'd15 || t !== 4'd1) begin errors++; $display("[TB] FAIL single_result: got %0d tag %0d expected 15 tag 1", p, t); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_release: got %0b expected 0", bus.res_valid); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    logic [PW-1:0] p;
    logic [TAG_W-1:0] t;
    logic [WIDTH-1:0] va [4];
    logic [WIDTH-1:0] vb [4];
    va = '{8'd255, 8'd0, 8'd1, 8'd16};
    vb = '{8'd255, 8'd7, 8'd1, 8'd16};
    applyStimulus(8'd2, 8'd3, 4'd15, ok);
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_filler: got timeout expected result"); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(va[i], vb[i], TAG_W'(i), ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_push%0d: got timeout expected accept", i); end
    end
    checks++; if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full: got count=%0d ready=%0b expected 4/0", bus.fifo_count, bus.in_ready); end
    for (int i = 0; i < 5; i++) begin
      grab_result(p, t, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || p !== e.p || t !== e.t) begin errors++; $display("[TB] FAIL b2b_result%0d: got %0d tag %0d expected %0d tag %0d", i, p, t, e.p, e.t); end
    end
  endtask

  task automatic test_hold();
    bit ok, stable, started;
    exp_t e;
    logic [PW-1:0] p;
    logic [TAG_W-1:0] t;
    applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 4'd5, ok);
    applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 4'd6, ok);
    wait_res(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL hold_first: got timeout expected result"); end
    e = exp_q[0];
    stable  = 1'b1;
    started = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_product !== e.p || bus.res_tag !== e.t) stable = 1'b0;
      if (bus.mul_start !== 1'b0) started = 1'b1;
      @(negedge clk);
    end
    checks++; if (!stable) begin errors++; $display("[TB] FAIL hold_stable: got 0 expected 1"); end
    checks++; if (started) begin errors++; $display("[TB] FAIL hold_no_issue: got start expected none"); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 1", bus.fifo_count); end
    for (int i = 0; i < 2; i++) begin
      grab_result(p, t, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || p !== e.p || t !== e.t) begin errors++; $display("[TB] FAIL hold_result%0d: got %0d tag %0d expected %0d tag %0d", i, p, t, e.p, e.t); end
    end
  endtask

  task automatic test_stale_done();
    bit ok, seen_busy, quiet;
    exp_t e;
    logic [PW-1:0] p;
    logic [TAG_W-1:0] t;
    logic [WIDTH-1:0] a, b;
    busy_delay_cfg = 3;
    a = WIDTH'($urandom_range(1, 254));
    b = WIDTH'($urandom_range(1, 255));
    if (ref_mul(int'(a), int'(b)) == bus.mul_product) a = a + 8'd1;
    applyStimulus(a, b, 4'd9, ok);
    seen_busy = 1'b0;
    quiet     = 1'b1;
    for (int i = 0; i < 60 && !seen_busy; i++) begin
      if (bus.mul_busy === 1'b1) seen_busy = 1'b1;
      else begin
        if (bus.res_valid !== 1'b0) quiet = 1'b0;
        @(negedge clk);
      end
    end
    checks++; if (!seen_busy) begin errors++; $display("[TB] FAIL stale_busy: got timeout expected busy"); end
    checks++; if (!quiet) begin errors++; $display("[TB] FAIL stale_early_capture: got res_valid expected 0"); end
    grab_result(p, t, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || p !== e.p || t !== e.t) begin errors++; $display("[TB] FAIL stale_result: got %0d tag %0d expected %0d tag %0d", p, t, e.p, e.t); end
    busy_delay_cfg = 0;
  endtask

  task automatic test_random();
    localparam int N = 40;
    int sent = 0;
    int got  = 0;
    bit pend = 1'b0;
    bit accepted;
    exp_t e;
    logic [WIDTH-1:0] ra, rb;
    logic [TAG_W-1:0] rt;
    for (int cyc = 0; cyc < 4000 && got < N; cyc++) begin
      if (!pend && sent < N && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        ra = WIDTH'($urandom);
        rb = WIDTH'($urandom);
        rt = TAG_W'($urandom);
      end
      bus.in_valid  = pend;
      bus.in_a      = ra;
      bus.in_b      = rb;
      bus.in_tag    = rt;
      bus.res_ready = 1'($urandom_range(0, 1));
      busy_delay_cfg = $urandom_range(0, 2);
      accepted = pend && (bus.in_ready === 1'b1);
      if (bus.res_valid === 1'b1 && bus.res_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL rand_extra: got %0d tag %0d expected no result", bus.res_product, bus.res_tag);
        end else begin
          e = exp_q.pop_front();
          if (bus.res_product !== e.p || bus.res_tag !== e.t) begin
            errors++; $display("[TB] FAIL rand_result%0d: got %0d tag %0d expected %0d tag %0d", got, bus.res_product, bus.res_tag, e.p, e.t);
          end
        end
        got++;
      end
      if (accepted) begin
        e.p = ref_mul(int'(ra), int'(rb));
        e.t = rt;
        exp_q.push_back(e);
        sent++;
        pend = 1'b0;
      end
      @(negedge clk);
    end
    bus.in_valid   = 1'b0;
    bus.res_ready  = 1'b0;
    busy_delay_cfg = 0;
    checks++; if (got != N) begin errors++; $display("[TB] FAIL rand_count: got %0d expected %0d", got, N); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen, quiet;
    for (int i = 0; i < 3; i++) applyStimulus(WIDTH'($urandom), WIDTH'($urandom), TAG_W'(i), ok);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.mul_busy === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL rmid_busy: got timeout expected busy"); end
    @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd2) begin errors++; $display("[TB] FAIL rmid_queued: got %0d expected 2", bus.fifo_count); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== '0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_fifo: got count=%0d ready=%0b expected 0/1", bus.fifo_count, bus.in_ready); end
    checks++; if (bus.mul_start !== 1'b0 || bus.mul_a !== '0 || bus.mul_b !== '0) begin errors++; $display("[TB] FAIL rmid_mul: got %0b %0d %0d expected 0 0 0", bus.mul_start, bus.mul_a, bus.mul_b); end
    checks++; if (bus.res_valid !== 1'b0 || bus.res_product !== '0 || bus.res_tag !== '0) begin errors++; $display("[TB] FAIL rmid_res: got %0b %0d %0d expected 0 0 0", bus.res_valid, bus.res_product, bus.res_tag); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.res_valid !== 1'b0 || bus.mul_start !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    checks++; if (!quiet) begin errors++; $display("[TB] FAIL rmid_quiet: got activity expected none"); end
  endtask

  task automatic test_full_pop();
    bit ok, quiet;
    exp_t e;
    logic [PW-1:0] p;
    logic [TAG_W-1:0] t;
    applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 4'd10, ok);
    wait_res(ok);
    for (int i = 0; i < 4; i++) applyStimulus(WIDTH'($urandom), WIDTH'($urandom), TAG_W'(11 + i), ok);
    e = exp_q.pop_front();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_product !== e.p || bus.res_tag !== e.t) begin errors++; $display("[TB] FAIL full_held: got %0d tag %0d expected %0d tag %0d", bus.res_product, bus.res_tag, e.p, e.t); end
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hAA;
    bus.in_b      = 8'h55;
    bus.in_tag    = 4'd7;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    checks++; if (bus.fifo_count !== 3'd4 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_before_pop: got count=%0d ready=%0b valid=%0b expected 4/0/0", bus.fifo_count, bus.in_ready, bus.res_valid); end
    @(negedge clk);
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("[TB] FAIL full_pop_count: got %0d expected 3", bus.fifo_count); end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      grab_result(p, t, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || p !== e.p || t !== e.t) begin errors++; $display("[TB] FAIL full_result%0d: got %0d tag %0d expected %0d tag %0d", i, p, t, e.p, e.t); end
    end
    bus.res_ready = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.res_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    bus.res_ready = 1'b0;
    checks++; if (!quiet || bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL full_no_extra: got quiet=%0b count=%0d expected 1/0", quiet, bus.fifo_count); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_stale_done();
    test_random();
    test_reset_mid();
    test_full_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
